// File: rtl/tdm_ingress_mux_if.sv
// rtl/tdm_ingress_mux_if.sv - per-port ingress streams and shared TDM byte lane
interface tdm_ingress_mux_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_PORTS  = 12
);
  logic [NUM_PORTS-1:0]            in_valid;
  logic [NUM_PORTS-1:0]            in_sop;
  logic [NUM_PORTS*DATA_WIDTH-1:0] in_data;
  logic [NUM_PORTS-1:0]            in_ready;
  logic                            output_wire;
  logic                            output_new_packet;
  logic [DATA_WIDTH-1:0]           output_data;
  logic [7:0]                      output_slot;

  modport master (
    output in_valid, in_sop, in_data,
    input  in_ready, output_wire, output_new_packet, output_data, output_slot
  );

  modport slave (
    input  in_valid, in_sop, in_data,
    output in_ready, output_wire, output_new_packet, output_data, output_slot
  );
endinterface

// File: rtl/tdm_ingress_mux.sv
// rtl/tdm_ingress_mux.sv - per-port FIFOs serialised onto one byte lane, one slot per port per 256-cycle frame
// Optional per-port saturating pop counters under TDM_STATS_EN.
module tdm_ingress_mux #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_PORTS  = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  tdm_ingress_mux_if.slave     bus,
  input  logic [7:0]           stat_sel,
  output logic [15:0]          stat_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = DATA_WIDTH + 1;

  logic [7:0]           slot_cnt;
  logic [NUM_PORTS-1:0] ready;
  logic [NUM_PORTS-1:0] push;
  logic [NUM_PORTS-1:0] pop;
  logic [EW-1:0]        head [NUM_PORTS];
  logic [EW-1:0]        pop_entry;

  assign bus.in_ready = ready;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;

    // Ready comes from the registered count only, so a full FIFO never accepts on its pop cycle.
    assign ready[p] = (count != CW'(FIFO_DEPTH));
    assign push[p]  = bus.in_valid[p] && ready[p];
    assign pop[p]   = (slot_cnt == 8'(p)) && (count != '0);
    assign head[p]  = mem[rd_ptr];

    always_ff @(posedge clk) begin
      if (push[p]) begin
        mem[wr_ptr] <= {bus.in_sop[p], bus.in_data[p*DATA_WIDTH +: DATA_WIDTH]};
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push[p]) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (pop[p]) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        case ({push[p], pop[p]})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  always_comb begin
    pop_entry = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (pop[p]) begin
        pop_entry = head[p];
      end
    end
  end

  // When a port pops, slot_cnt equals that port, so output_slot is slot_cnt either way.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt              <= '0;
      bus.output_wire       <= 1'b0;
      bus.output_new_packet <= 1'b0;
      bus.output_data       <= '0;
      bus.output_slot       <= '0;
    end else begin
      slot_cnt              <= slot_cnt + 8'd1;
      bus.output_wire       <= |pop;
      bus.output_new_packet <= (|pop) && pop_entry[DATA_WIDTH];
      bus.output_data       <= (|pop) ? pop_entry[DATA_WIDTH-1:0] : '0;
      bus.output_slot       <= slot_cnt;
    end
  end

`ifdef TDM_STATS_EN
  logic [15:0] stat_cnt [NUM_PORTS];
  logic [15:0] stat_sel_val;

  always_comb begin
    stat_sel_val = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (stat_sel == 8'(p)) begin
        stat_sel_val = stat_cnt[p];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        stat_cnt[p] <= '0;
      end
      stat_count <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (pop[p] && (stat_cnt[p] != 16'hFFFF)) begin
          stat_cnt[p] <= stat_cnt[p] + 16'd1;
        end
      end
      stat_count <= stat_sel_val;
    end
  end
`else
  logic unused_stat_sel;
  assign unused_stat_sel = ^stat_sel;
  assign stat_count      = '0;
`endif
endmodule

// File: tb/tb_tdm_ingress_mux.sv
// tb/tb_tdm_ingress_mux.sv - scoreboard bench for tdm_ingress_mux against a queue-based frame model
module tb_tdm_ingress_mux;
  localparam int NP    = 12;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic       w;
    logic       sop;
    logic [7:0] d;
    logic [7:0] slot;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  stat_sel = 8'd0;
  logic [15:0] stat_count;

  tdm_ingress_mux_if #(.DATA_WIDTH(8), .NUM_PORTS(NP)) bus ();

  tdm_ingress_mux #(.DATA_WIDTH(8), .NUM_PORTS(NP), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .stat_sel   (stat_sel),
    .stat_count (stat_count)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  int   cycle = 0;
  exp_t exp_q [$];
  exp_t got;
  exp_t want;

  logic [8:0]  src [NP][$];
  logic [8:0]  mq  [NP][$];
  logic [7:0]  ms = 8'd0;
  bit          model_ok = 1'b0;
  bit          gate = 1'b0;
  int unsigned mcnt [NP];

  // Monitor: one expected lane word per modelled clock edge.
  always @(posedge clk) begin
    #1;
    cycle++;
    if (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      got  = {bus.output_wire, bus.output_new_packet, bus.output_data, bus.output_slot};
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL lane cyc=%0d got w=%b sop=%b d=%h slot=%0d want w=%b sop=%b d=%h slot=%0d",
                 cycle, got.w, got.sop, got.d, got.slot, want.w, want.sop, want.d, want.slot);
      end
    end
  end

  // Drive one cycle of stimulus and advance the frame model across the following edge.
  task automatic cyc(input bit r);
    logic [NP-1:0]   v;
    logic [NP-1:0]   sp;
    logic [NP*8-1:0] d;
    logic [NP-1:0]   rdy;
    exp_t            e;
    @(negedge clk);
    for (int p = 0; p < NP; p++) begin
      rdy[p] = (mq[p].size() != DEPTH);
    end
    if (model_ok) begin
      total++;
      if (bus.in_ready !== rdy) begin
        bad++;
        $display("FAIL in_ready got %b want %b", bus.in_ready, rdy);
      end
    end
    v = '0; sp = '0; d = '0;
    for (int p = 0; p < NP; p++) begin
      if (src[p].size() > 0 && (!gate || $urandom_range(3) != 0)) begin
        v[p]        = 1'b1;
        sp[p]       = src[p][0][8];
        d[p*8 +: 8] = src[p][0][7:0];
      end
    end
    bus.in_valid = v;
    bus.in_sop   = sp;
    bus.in_data  = d;
    rst          = r;
    if (r) begin
      for (int p = 0; p < NP; p++) begin
        mq[p].delete();
        mcnt[p] = 0;
      end
      e        = '0;
      ms       = 8'd0;
      model_ok = 1'b1;
    end else begin
      e = {1'b0, 1'b0, 8'h00, ms};
      if (int'(ms) < NP && mq[ms].size() > 0) begin
        e = {1'b1, mq[ms][0][8], mq[ms][0][7:0], ms};
        void'(mq[ms].pop_front());
        if (mcnt[ms] < 32'hFFFF) mcnt[ms]++;
      end
      for (int p = 0; p < NP; p++) begin
        if (v[p] && rdy[p]) mq[p].push_back(src[p].pop_front());
      end
      ms = ms + 8'd1;
    end
    exp_q.push_back(e);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0);
  endtask

  task automatic wait_slot(input int s);
    while (ms != 8'(s)) cyc(1'b0);
  endtask

  initial begin
    bus.in_valid = '0;
    bus.in_sop   = '0;
    bus.in_data  = '0;
    cyc(1'b1);
    cyc(1'b1);
    run(300);

    wait_slot(10);
    src[3].push_back({1'b1, 8'hA5});
    run(300);

    for (int i = 0; i < 5; i++) src[0].push_back({(i == 0), 8'(8'h10 + i)});
    run(256 * 6);

    gate = 1'b1;
    for (int p = 0; p < NP; p++)
      for (int i = 0; i < 3; i++) src[p].push_back(9'($urandom));
    run(256 * 5);

    gate = 1'b0;
    wait_slot(200);
    src[5].push_back({1'b1, 8'h51});
    src[5].push_back({1'b0, 8'h52});
    wait_slot(5);
    src[5].push_back({1'b0, 8'h53});
    run(256);
    wait_slot(200);
    for (int i = 0; i < 6; i++) src[5].push_back({1'b0, 8'(8'h60 + i)});
    run(256 * 3);

    wait_slot(20);
    for (int i = 0; i < 2; i++) begin
      src[1].push_back(9'($urandom));
      src[4].push_back(9'($urandom));
      src[7].push_back(9'($urandom));
    end
    wait_slot(100);
    for (int p = 0; p < NP; p++) src[p].delete();
    cyc(1'b1);
    run(300);

    gate = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      int p;
      p = $urandom_range(NP - 1);
      if (src[p].size() < 3) src[p].push_back(9'($urandom));
      cyc(1'b0);
    end
    for (int p = 0; p < NP; p++) src[p].delete();
    run(256 * 6);

`ifdef TDM_STATS_EN
    stat_sel = 8'd2;
    cyc(1'b0);
    @(posedge clk);
    #2;
    total++;
    if (stat_count !== 16'(mcnt[2])) begin
      bad++;
      $display("FAIL stat_sel2 got %0d want %0d", stat_count, mcnt[2]);
    end
    stat_sel = 8'd200;
    cyc(1'b0);
    @(posedge clk);
    #2;
    total++;
    if (stat_count !== 16'd0) begin
      bad++;
      $display("FAIL stat_sel200 got %0d want 0", stat_count);
    end
`endif

    run(2);
    @(posedge clk);
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
